// File: rtl/button_pkg.sv
// Shared button/command definitions used by the encoder and by LEDController.
package button_pkg;

  localparam int unsigned NUM_BTN   = 8;

  // SIGNAL bit positions understood by LEDController
  localparam int unsigned SIG_UP    = 0;
  localparam int unsigned SIG_DOWN  = 2;
  localparam int unsigned SIG_LEFT  = 3;
  localparam int unsigned SIG_RIGHT = 4;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  // Isolate the lowest set bit as a one-hot vector (zero in, zero out).
  function automatic btn_vec_t lowest_set(input btn_vec_t v);
    return v & (~v + btn_vec_t'(1));
  endfunction

endpackage

// File: rtl/button_signal_encoder_if.sv
// Button-side bundle: raw buttons in, command pulses and debounced levels out.
interface button_signal_encoder_if;
  import button_pkg::*;

  btn_vec_t BTN;
  btn_vec_t SIGNAL;
  btn_vec_t HELD;
  logic     BUSY;

  modport master (output BTN, input SIGNAL, input HELD, input BUSY);
  modport slave  (input BTN, output SIGNAL, output HELD, output BUSY);

endinterface

// File: rtl/button_debounce.sv
// Single-bit two-flop synchroniser followed by a stable-run-length debouncer.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic HELD
);

  // counter only needs to reach DEBOUNCE_CYCLES-1; the toggle happens instead of the final increment
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // synchronise the raw level and accept a change only after a full stable run
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      HELD <= 1'b0;
    end else begin
      s1 <= BTN;
      s2 <= s1;
      if (s2 != HELD) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          HELD <= ~HELD;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/button_signal_encoder.sv
// Debounces eight buttons, queues presses and issues them as one-hot single-cycle
// SIGNAL pulses, lowest index first, with optional shared auto-repeat.
module button_signal_encoder
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
  input logic                     CLK,
  input logic                     RST,
  button_signal_encoder_if.slave  bus
);

  localparam logic        REP_EN = (REPEAT_DELAY != 0);
  localparam int unsigned RTOP   = REPEAT_DELAY + REPEAT_PERIOD;
  localparam int unsigned RW     = (RTOP > 2) ? $clog2(RTOP) : 1;

  btn_vec_t      held;
  btn_vec_t      held_d;
  btn_vec_t      pend;
  btn_vec_t      pend_nxt;
  btn_vec_t      pick;
  btn_vec_t      press;
  btn_vec_t      rep_mask;
  btn_vec_t      sig_q;
  logic          busy_q;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nxt;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .CLK (CLK),
      .RST (RST),
      .BTN (bus.BTN[g]),
      .HELD(held[g])
    );
  end

  // priority pick, press/repeat queueing and repeat-counter advance
  always_comb begin
    pick     = lowest_set(pend);
    press    = held & ~held_d;
    rep_mask = '0;
    if (REP_EN && (rcnt == RW'(REPEAT_DELAY))) begin
      rep_mask = held;
    end
    // new requests are ORed in after the issued bit is cleared, so a set beats a clear
    pend_nxt = (pend & ~pick) | press | rep_mask;

    // rcnt folds the period back onto REPEAT_DELAY, so every repeat fires at rcnt == REPEAT_DELAY
    rcnt_nxt = rcnt + RW'(1);
    if (!REP_EN || (held == '0) || (held != held_d)) begin
      rcnt_nxt = '0;
    end else if (rcnt == RW'(RTOP - 1)) begin
      rcnt_nxt = RW'(REPEAT_DELAY);
    end
  end

  // queue, output and repeat-counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend   <= '0;
      held_d <= '0;
      sig_q  <= '0;
      busy_q <= 1'b0;
      rcnt   <= '0;
    end else begin
      pend   <= pend_nxt;
      held_d <= held;
      sig_q  <= pick;
      busy_q <= |pend_nxt;
      rcnt   <= rcnt_nxt;
    end
  end

  assign bus.SIGNAL = sig_q;
  assign bus.HELD   = held;
  assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_button_signal_encoder.sv
// Bench for button_signal_encoder: two instances (repeat enabled / disabled) driven
// by the same buttons, compared every cycle against a behavioural model, plus
// scenario-level checks.
module tb_button_signal_encoder;
  import button_pkg::*;

  localparam int DB = 4;
  localparam int RP = 6;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] btn;

  always #5 CLK = ~CLK;

  button_signal_encoder_if bus_r ();
  button_signal_encoder_if bus_n ();

  assign bus_r.BTN = btn;
  assign bus_n.BTN = btn;

  button_signal_encoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (6)
  ) dut_r (
    .CLK(CLK),
    .RST(RST),
    .bus(bus_r)
  );

  button_signal_encoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (0),
    .REPEAT_PERIOD  (6)
  ) dut_n (
    .CLK(CLK),
    .RST(RST),
    .bus(bus_n)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model, index 0 = repeat enabled, 1 = repeat disabled
  int         rd[2] = '{20, 0};
  logic [7:0] m_s1[2], m_s2[2], m_held[2], m_hprev[2], m_pend[2], m_sig[2];
  logic       m_busy[2];
  int         m_dc[2][8];
  int         m_hold_age[2];

  task automatic model_step(input int k, input logic [7:0] b, input logic r);
    logic [7:0] nh, np, ns, press, rep;
    if (r) begin
      m_s1[k] = '0; m_s2[k] = '0; m_held[k] = '0; m_hprev[k] = '0;
      m_pend[k] = '0; m_sig[k] = '0; m_busy[k] = 1'b0; m_hold_age[k] = 0;
      for (int i = 0; i < 8; i++) m_dc[k][i] = 0;
      return;
    end
    nh = m_held[k];
    for (int i = 0; i < 8; i++) begin
      if (m_s2[k][i] != m_held[k][i]) begin
        if (m_dc[k][i] + 1 >= DB) begin
          nh[i] = ~nh[i];
          m_dc[k][i] = 0;
        end else begin
          m_dc[k][i] = m_dc[k][i] + 1;
        end
      end else begin
        m_dc[k][i] = 0;
      end
    end
    press = m_held[k] & ~m_hprev[k];
    rep = '0;
    if (rd[k] != 0 && m_hold_age[k] >= rd[k] && ((m_hold_age[k] - rd[k]) % RP) == 0)
      rep = m_held[k];
    ns = '0;
    for (int i = 0; i < 8; i++) begin
      if (m_pend[k][i]) begin
        ns[i] = 1'b1;
        break;
      end
    end
    np = (m_pend[k] & ~ns) | press | rep;
    m_hold_age[k] = (m_held[k] == '0 || m_held[k] != m_hprev[k]) ? 0 : m_hold_age[k] + 1;
    m_hprev[k] = m_held[k];
    m_held[k]  = nh;
    m_s2[k]    = m_s1[k];
    m_s1[k]    = b;
    m_sig[k]   = ns;
    m_pend[k]  = np;
    m_busy[k]  = |np;
  endtask

  task automatic step(input logic [7:0] b, input logic r);
    btn = b;
    RST = r;
    @(posedge CLK);
    model_step(0, b, r);
    model_step(1, b, r);
    #1;
    chk("sig_r",    32'(bus_r.SIGNAL), 32'(m_sig[0]));
    chk("held_r",   32'(bus_r.HELD),   32'(m_held[0]));
    chk("busy_r",   32'(bus_r.BUSY),   32'(m_busy[0]));
    chk("sig_n",    32'(bus_n.SIGNAL), 32'(m_sig[1]));
    chk("held_n",   32'(bus_n.HELD),   32'(m_held[1]));
    chk("busy_n",   32'(bus_n.BUSY),   32'(m_busy[1]));
    chk("onehot_r", 32'($countones(bus_r.SIGNAL) <= 1), 32'(1));
    @(negedge CLK);
  endtask

  task automatic do_reset();
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
  endtask

  initial begin
    int         first_held, first_sig, npulse, npulse_n, after_rel, e6, acc;
    logic       rel_seen;
    logic [7:0] seq[$];
    int         eds[$];
    logic [7:0] cur;
    logic       rr;

    do_reset();
    chk("reset_sig",  32'(bus_r.SIGNAL), 32'(0));
    chk("reset_held", 32'(bus_r.HELD),   32'(0));
    chk("reset_busy", 32'(bus_r.BUSY),   32'(0));

    // 1: single press
    first_held = -1; first_sig = -1; npulse = 0;
    for (int e = 0; e < 26; e++) begin
      step(8'h01, 1'b0);
      if (first_held < 0 && bus_r.HELD[0]) first_held = e;
      if (bus_r.SIGNAL != 8'h00) begin
        npulse++;
        if (first_sig < 0) first_sig = e;
        chk("s1_val", 32'(bus_r.SIGNAL), 32'(8'h01));
      end
    end
    chk("s1_held_edge", 32'(first_held), 32'(5));
    chk("s1_sig_edge",  32'(first_sig),  32'(7));
    chk("s1_count",     32'(npulse),     32'(1));
    for (int e = 0; e < 12; e++) step(8'h00, 1'b0);
    do_reset();

    // 2: bounce shorter than the debounce window
    acc = 0;
    for (int e = 0; e < 20; e++) begin
      cur = (e < 4 && (e % 2) == 0) ? 8'h04 : 8'h00;
      step(cur, 1'b0);
      acc = acc | int'(bus_r.HELD) | int'(bus_r.SIGNAL);
    end
    chk("s2_quiet", 32'(acc), 32'(0));
    do_reset();

    // 3: simultaneous press drains in ascending order
    seq.delete(); eds.delete();
    for (int e = 0; e < 15; e++) begin
      step(8'h1C, 1'b0);
      if (bus_r.SIGNAL != 8'h00) begin
        seq.push_back(bus_r.SIGNAL);
        eds.push_back(e);
      end
      if (e == 8) chk("s3_busy_e8", 32'(bus_r.BUSY), 32'(1));
      if (e == 9) chk("s3_busy_e9", 32'(bus_r.BUSY), 32'(0));
    end
    chk("s3_npulse", 32'(seq.size()), 32'(3));
    if (seq.size() == 3) begin
      chk("s3_p0", 32'(seq[0]), 32'(8'h04));
      chk("s3_p1", 32'(seq[1]), 32'(8'h08));
      chk("s3_p2", 32'(seq[2]), 32'(8'h10));
      chk("s3_e0", 32'(eds[0]), 32'(7));
      chk("s3_e2", 32'(eds[2]), 32'(9));
    end
    for (int e = 0; e < 12; e++) step(8'h00, 1'b0);
    do_reset();

    // 4 + 5: held button, repeat enabled vs disabled
    npulse = 0; npulse_n = 0; first_sig = -1; after_rel = 0; rel_seen = 1'b0;
    for (int e = 0; e < 85; e++) begin
      step((e < 60) ? 8'h10 : 8'h00, 1'b0);
      if (bus_r.SIGNAL != 8'h00) begin
        npulse++;
        if (first_sig < 0) first_sig = e;
        if (rel_seen) after_rel++;
      end
      if (bus_n.SIGNAL != 8'h00) begin
        npulse_n++;
        chk("s5_val", 32'(bus_n.SIGNAL), 32'(8'h10));
      end
      if (e >= 60 && bus_r.HELD == 8'h00) rel_seen = 1'b1;
    end
    chk("s4_first",     32'(first_sig),        32'(7));
    chk("s4_repeats",   32'(npulse > 3),       32'(1));
    chk("s4_after_rel", 32'(after_rel),        32'(0));
    chk("s5_count",     32'(npulse_n),         32'(1));
    do_reset();

    // 6: reset while two presses are queued
    e6 = 0;
    for (int e = 0; e < 7; e++) step(8'h18, 1'b0);
    chk("s6_busy_pre", 32'(bus_r.BUSY), 32'(1));
    step(8'h18, 1'b1);
    chk("s6_sig_rst",  32'(bus_r.SIGNAL), 32'(0));
    chk("s6_busy_rst", 32'(bus_r.BUSY),   32'(0));
    chk("s6_held_rst", 32'(bus_r.HELD),   32'(0));
    seq.delete(); eds.delete();
    for (int e = 1; e <= 16; e++) begin
      step(8'h18, 1'b0);
      if (bus_r.SIGNAL != 8'h00) begin
        seq.push_back(bus_r.SIGNAL);
        eds.push_back(e);
      end
    end
    chk("s6_npulse", 32'(seq.size()), 32'(2));
    if (seq.size() == 2) begin
      chk("s6_p0", 32'(seq[0]), 32'(8'h08));
      chk("s6_p1", 32'(seq[1]), 32'(8'h10));
      chk("s6_e0", 32'(eds[0]), 32'(8));
    end
    for (int e = 0; e < 12; e++) step(8'h00, 1'b0);
    do_reset();

    // random bouncing buttons with occasional resets
    cur = 8'h00;
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 99)) inside
        [0:9]:   cur = cur ^ (8'h01 << $urandom_range(0, 7));
        [10:11]: cur = 8'($urandom);
        default: ;
      endcase
      rr = ($urandom_range(0, 199) == 0);
      step(cur, rr);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
